rf_wb_reader: RTL and testbench
===============================

Name: rf_wb_reader

Overview:
- Architectural register file: the consumer of the write-back datum `rf_w_data_DM_WB` produced at the DM/WB boundary.
- Accepts one write per cycle from WB.
- Serves two registered read ports to ID: p0/p1 operands, one cycle latency.
- Includes same-cycle write-to-read bypass, R0 hardwired to zero, and a stall hold so ID can freeze operands.

Parameters:
- DATA_W, 32, datapath width (matches the WB data width).
- ADDR_W, 4, register address width.
- NUM_REGS, 16, register count (R15 is the JAL link register; no special handling here).

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- p0_addr  input  ADDR_W  read port 0 address (from ID).
- p1_addr  input  ADDR_W  read port 1 address (from ID).
- re0  input  1  read enable port 0; low = hold p0.
- re1  input  1  read enable port 1; low = hold p1.
- dst_addr  input  ADDR_W  write address from WB.
- dst  input  DATA_W  write data (`rf_w_data_DM_WB`).
- we  input  1  write enable from WB.
- hlt  input  1  halt; blocks all writes and holds read outputs.
- p0  output  DATA_W  registered read data, port 0.
- p1  output  DATA_W  registered read data, port 1.

Behaviour:
- Reset is asynchronous, active-high: clk and rst; reset is asynchronous and active-high.
  - Asserting rst immediately clears all NUM_REGS entries, p0 and p1 to 0.
  - Deasserting rst takes effect at the next rising edge.
- Write: on a rising edge with we=1, hlt=0 and dst_addr!=0, mem[dst_addr] <= dst.
  - Writes to address 0 are discarded; mem[0] stays 0.
- Read latency is one cycle.
  - On a rising edge with reN=1 and hlt=0, pN <= value(pN_addr).
  - Otherwise pN holds its previous value (stall).
- value(a) is defined as:
  - 0 if a==0;
  - else dst if (we && !hlt && dst_addr==a), the same-edge write-through bypass;
  - else mem[a].
- Simultaneous events:
  - Both ports reading the same address return the same value.
  - A write and a read to the same address on one edge: the read returns the new data.
  - A write to R0 while reading R0: the read returns 0.
- hlt=1 blocks writes even if we=1, and holds both outputs.
- Reset mid-operation: a pending write on the edge coincident with rst is lost. Register contents are not preserved across reset.
- No X propagation: outputs are always defined after reset.
- Width rules: no arithmetic. Addresses are compared at full ADDR_W; NUM_REGS must equal 2**ADDR_W.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W defaults;
  - localparam REG_ZERO=0;
  - localparam REG_LINK=15, the JAL destination, shared with dst_mux and the ID decoder.
- One natural sub-module: rf_bypass_sel, the combinational value(a) selector. It is instantiated twice, once per read port.
- The storage array and output registers live in the top module.

Test Plan:
1. Reset: pulse rst mid-cycle after writing R3=0xDEADBEEF → p0/p1 go to 0 immediately (before any edge). A subsequent read of R3 returns 0x00000000.
2. Write/read: we=1, dst_addr=5, dst=0x12345678, then next cycle p0_addr=5, re0=1 → p0=0x12345678 one edge later.
3. Bypass: same edge with we=1, dst_addr=7, dst=0xA5A5A5A5, p1_addr=7, re1=1 → p1=0xA5A5A5A5 after that edge. Old mem[7] is never visible.
4. R0 protection: we=1, dst_addr=0, dst=0xFFFFFFFF, with a simultaneous read of R0 on both ports → p0=p1=0; re-reading later is still 0.
5. Stall/halt:
   - Load R2=0x11, R4=0x22 and read them to p0/p1.
   - Then re0=0, re1=0 with the addresses changed → outputs hold 0x11/0x22.
   - Then hlt=1 with we=1, dst_addr=2, dst=0x99 → R2 remains 0x11 on a later read.
6. Link register: write R15=0x00000104 (JAL return PC) and read it on both ports → both return 0x00000104. Confirm no other register changed.

Source files
------------

// File: rtl/rf_wb_reader_pkg.sv
// Shared constants for the architectural register file and its neighbours
// (dst_mux, ID decoder).
package rf_wb_reader_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;
  localparam int REG_ZERO  = 0;
  localparam int REG_LINK  = 15;  // JAL destination

endpackage

// File: rtl/rf_bypass_sel.sv
// Combinational read-value selector for one read port: R0 reads as zero,
// a same-edge WB write to the read address is forwarded, else storage.
module rf_bypass_sel
  import rf_wb_reader_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] value_o
);

  always_comb begin
    value_o = mem_data_i;
    if (rd_addr_i == ADDR_W'(REG_ZERO)) begin
      value_o = '0;
    end else if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      value_o = wr_data_i;
    end
  end

endmodule

// File: rtl/rf_wb_reader.sv
// Architectural register file fed by the WB stage: one write port, two
// registered read ports with write-through bypass and stall/halt hold.
module rf_wb_reader
  import rf_wb_reader_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              re0,
  input  logic              re1,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [DATA_W-1:0] dst,
  input  logic              we,
  input  logic              hlt,
  output logic [DATA_W-1:0] p0,
  output logic [DATA_W-1:0] p1
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic              wr_en;
  logic              wr_commit;

  logic [ADDR_W-1:0] rd_addr  [2];
  logic              rd_en    [2];
  logic [DATA_W-1:0] rd_value [2];
  logic [DATA_W-1:0] p_d      [2];
  logic [DATA_W-1:0] p_q      [2];

  assign wr_en     = we && !hlt;
  // R0 never gets written, so its flop stays at the reset value of zero.
  assign wr_commit = wr_en && (dst_addr != ADDR_W'(REG_ZERO));

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else if (wr_commit && (dst_addr == ADDR_W'(gi))) begin
          mem_q[gi] <= dst;
        end
      end
    end
  endgenerate

  assign rd_addr[0] = p0_addr;
  assign rd_addr[1] = p1_addr;
  assign rd_en[0]   = re0;
  assign rd_en[1]   = re1;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      rf_bypass_sel #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_sel (
        .rd_addr_i  (rd_addr[gi]),
        .mem_data_i (mem_q[rd_addr[gi]]),
        .wr_en_i    (wr_en),
        .wr_addr_i  (dst_addr),
        .wr_data_i  (dst),
        .value_o    (rd_value[gi])
      );

      always_comb begin
        p_d[gi] = p_q[gi];
        if (rd_en[gi] && !hlt) begin
          p_d[gi] = rd_value[gi];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_q[gi] <= '0;
        end else begin
          p_q[gi] <= p_d[gi];
        end
      end
    end
  endgenerate

  assign p0 = p_q[0];
  assign p1 = p_q[1];

endmodule

// File: tb/tb_rf_wb_reader.sv
// Self-checking bench for rf_wb_reader: a reference model predicts both read
// ports per edge into a scoreboard that each scenario drains and compares.
module tb_rf_wb_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  p0_addr, p1_addr, dst_addr;
  logic        re0, re1, we, hlt;
  logic [31:0] dst;
  logic [31:0] p0, p1;

  rf_wb_reader dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p1_addr(p1_addr),
    .re0(re0), .re1(re1),
    .dst_addr(dst_addr), .dst(dst), .we(we), .hlt(hlt),
    .p0(p0), .p1(p1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] v0;
    logic [31:0] v1;
  } item_t;

  item_t       exp_q[$];
  item_t       obs_q[$];
  logic [31:0] model_mem [16];
  logic [31:0] model_p0, model_p1;
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] mval(input logic [3:0] a, input logic [3:0] da,
                                       input logic [31:0] d, input logic w, input logic h);
    if (a == 4'd0) return 32'd0;
    if (w && !h && da == a) return d;
    return model_mem[a];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 32'd0;
    model_p0 = 32'd0;
    model_p1 = 32'd0;
  endfunction

  // One clock edge of stimulus: predict, push expectation, sample after edge.
  task automatic drive(input string name, input logic [3:0] a0, input logic [3:0] a1,
                       input logic r0, input logic r1, input logic [3:0] da,
                       input logic [31:0] d, input logic w, input logic h);
    item_t e, o;
    @(negedge clk);
    p0_addr = a0; p1_addr = a1; re0 = r0; re1 = r1;
    dst_addr = da; dst = d; we = w; hlt = h;
    e.name = name;
    e.v0 = (r0 && !h) ? mval(a0, da, d, w, h) : model_p0;
    e.v1 = (r1 && !h) ? mval(a1, da, d, w, h) : model_p1;
    if (w && !h && da != 4'd0) model_mem[da] = d;
    model_p0 = e.v0;
    model_p1 = e.v1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.name = name; o.v0 = p0; o.v1 = p1;
    obs_q.push_back(o);
    re0 = 1'b0; re1 = 1'b0; we = 1'b0; hlt = 1'b0;
  endtask

  task automatic test_reset();
    item_t e, o;
    n_checks += 2;
    if (p0 !== 32'd0) begin n_fail++; $display("FAIL reset_init p0 got %h want %h", p0, 32'd0); end
    if (p1 !== 32'd0) begin n_fail++; $display("FAIL reset_init p1 got %h want %h", p1, 32'd0); end
    drive("rst_wr_r3", 4'd0, 4'd0, 1'b0, 1'b0, 4'd3, 32'hDEADBEEF, 1'b1, 1'b0);
    drive("rst_rd_r3", 4'd3, 4'd3, 1'b1, 1'b1, 4'd0, 32'd0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks += 2;
      if (o.v0 !== e.v0) begin n_fail++; $display("FAIL %s p0 got %h want %h", e.name, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_fail++; $display("FAIL %s p1 got %h want %h", e.name, o.v1, e.v1); end
    end
    #2 rst = 1'b1;
    #1;
    n_checks += 2;
    if (p0 !== 32'd0) begin n_fail++; $display("FAIL async_rst p0 got %h want %h", p0, 32'd0); end
    if (p1 !== 32'd0) begin n_fail++; $display("FAIL async_rst p1 got %h want %h", p1, 32'd0); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive("rst_reread_r3", 4'd3, 4'd3, 1'b1, 1'b1, 4'd0, 32'd0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks += 2;
      if (o.v0 !== e.v0) begin n_fail++; $display("FAIL %s p0 got %h want %h", e.name, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_fail++; $display("FAIL %s p1 got %h want %h", e.name, o.v1, e.v1); end
    end
  endtask

  task automatic test_write_read();
    item_t e, o;
    drive("wr_r5", 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 32'h12345678, 1'b1, 1'b0);
    drive("rd_r5", 4'd5, 4'd0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks += 2;
      if (o.v0 !== e.v0) begin n_fail++; $display("FAIL %s p0 got %h want %h", e.name, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_fail++; $display("FAIL %s p1 got %h want %h", e.name, o.v1, e.v1); end
    end
  endtask

  task automatic test_bypass();
    item_t e, o;
    drive("byp_old_r7", 4'd0, 4'd0, 1'b0, 1'b0, 4'd7, 32'h00000077, 1'b1, 1'b0);
    drive("byp_r7",     4'd0, 4'd7, 1'b0, 1'b1, 4'd7, 32'hA5A5A5A5, 1'b1, 1'b0);
    drive("byp_both",   4'd7, 4'd7, 1'b1, 1'b1, 4'd7, 32'h5A5A0001, 1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks += 2;
      if (o.v0 !== e.v0) begin n_fail++; $display("FAIL %s p0 got %h want %h", e.name, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_fail++; $display("FAIL %s p1 got %h want %h", e.name, o.v1, e.v1); end
    end
  endtask

  task automatic test_r0();
    item_t e, o;
    drive("r0_wr_rd", 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
    drive("r0_reread", 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 32'd0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks += 2;
      if (o.v0 !== e.v0) begin n_fail++; $display("FAIL %s p0 got %h want %h", e.name, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_fail++; $display("FAIL %s p1 got %h want %h", e.name, o.v1, e.v1); end
    end
  endtask

  task automatic test_stall_halt();
    item_t e, o;
    drive("sh_wr_r2",  4'd0, 4'd0, 1'b0, 1'b0, 4'd2, 32'h11, 1'b1, 1'b0);
    drive("sh_wr_r4",  4'd0, 4'd0, 1'b0, 1'b0, 4'd4, 32'h22, 1'b1, 1'b0);
    drive("sh_rd",     4'd2, 4'd4, 1'b1, 1'b1, 4'd0, 32'd0, 1'b0, 1'b0);
    drive("sh_stall",  4'd5, 4'd7, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
    drive("sh_halt",   4'd2, 4'd2, 1'b1, 1'b1, 4'd2, 32'h99, 1'b1, 1'b1);
    drive("sh_rd_r2",  4'd2, 4'd2, 1'b1, 1'b1, 4'd0, 32'd0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks += 2;
      if (o.v0 !== e.v0) begin n_fail++; $display("FAIL %s p0 got %h want %h", e.name, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_fail++; $display("FAIL %s p1 got %h want %h", e.name, o.v1, e.v1); end
    end
  endtask

  task automatic test_link();
    item_t e, o;
    drive("lnk_wr", 4'd0, 4'd0, 1'b0, 1'b0, 4'd15, 32'h00000104, 1'b1, 1'b0);
    drive("lnk_rd", 4'd15, 4'd15, 1'b1, 1'b1, 4'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i += 2) begin
      drive($sformatf("lnk_scan_r%0d", i), 4'(i), 4'(i + 1), 1'b1, 1'b1, 4'd0, 32'd0, 1'b0, 1'b0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks += 2;
      if (o.v0 !== e.v0) begin n_fail++; $display("FAIL %s p0 got %h want %h", e.name, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_fail++; $display("FAIL %s p1 got %h want %h", e.name, o.v1, e.v1); end
    end
  endtask

  task automatic test_back_to_back();
    item_t e, o;
    for (int i = 0; i < 60; i++) begin
      drive($sformatf("b2b_%0d", i), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)), $urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks += 2;
      if (o.v0 !== e.v0) begin n_fail++; $display("FAIL %s p0 got %h want %h", e.name, o.v0, e.v0); end
      if (o.v1 !== e.v1) begin n_fail++; $display("FAIL %s p1 got %h want %h", e.name, o.v1, e.v1); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    p0_addr = '0; p1_addr = '0; dst_addr = '0; dst = '0;
    re0 = 1'b0; re1 = 1'b0; we = 1'b0; hlt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_stall_halt();
    test_link();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
